// File: rtl/du_pkg.sv
// Shared width and mode encodings for the shift-and-add multiplier datapath.
package du_pkg;
  localparam int W = 4;

  localparam logic CTRL_LOAD  = 1'b1;
  localparam logic CTRL_SHIFT = 1'b0;
  localparam logic PSEL_CLR   = 1'b0;
  localparam logic PSEL_ADD   = 1'b1;
endpackage

// File: rtl/du_shift_reg.sv
// Load/shift/hold register with async active-low clear; shift direction set by LEFT.
// Latency 1 cycle; no backpressure, updates whenever en is high.
module shift_reg
  import du_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit LEFT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shifted;

  // Vacated bit is always zero; the bit shifted out is discarded.
  always_comb begin
    shifted = '0;
    if (LEFT) shifted = {q[WIDTH-2:0], 1'b0};
    else      shifted = {1'b0, q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      case (mode)
        CTRL_LOAD:  q <= din;
        CTRL_SHIFT: q <= shifted;
        default:    q <= q;
      endcase
    end
  end

endmodule

// File: rtl/du.sv
// Datapath of a WxW shift-and-add multiplier: A shifts left, B shifts right, P accumulates.
// Latency 1 cycle per register update; no handshake, the external controller sequences every step.
module du
  import du_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ctrlA,
  input  logic         ctrlB,
  input  logic         ldA,
  input  logic         ldB,
  input  logic         Psel,
  input  logic         ldP,
  input  logic [W-1:0] dataA,
  input  logic [W-1:0] dataB,
  output logic         b0,
  output logic         z,
  output logic [2*W-1:0] P
);

  logic [2*W-1:0] a;
  logic [W-1:0]   b;
  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] p_sum;

  assign a_ext = {{W{1'b0}}, dataA};

  shift_reg #(.WIDTH(2*W), .LEFT(1'b1)) u_a (
    .clk  (clk),
    .rst  (rst),
    .en   (ldA),
    .mode (ctrlA),
    .din  (a_ext),
    .q    (a)
  );

  shift_reg #(.WIDTH(W), .LEFT(1'b0)) u_b (
    .clk  (clk),
    .rst  (rst),
    .en   (ldB),
    .mode (ctrlB),
    .din  (dataB),
    .q    (b)
  );

  // Add is unconditional and wraps; the controller gates it via ldP when b0 is set.
  assign p_sum = P + a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      P <= '0;
    end else if (ldP) begin
      case (Psel)
        PSEL_CLR: P <= '0;
        PSEL_ADD: P <= p_sum;
        default:  P <= P;
      endcase
    end
  end

  assign b0 = b[0];
  assign z  = (b == '0);

endmodule

// File: tb/tb_du.sv
// Directed-vector bench for the multiplier datapath du.
module tb_du;
  import du_pkg::*;

  logic           clk;
  logic           rst;
  logic           ctrlA, ctrlB, ldA, ldB, Psel, ldP;
  logic [W-1:0]   dataA, dataB;
  logic           b0, z;
  logic [2*W-1:0] P;

  int n_cmp;
  int n_bad;

  du dut (
    .clk   (clk),
    .rst   (rst),
    .ctrlA (ctrlA),
    .ctrlB (ctrlB),
    .ldA   (ldA),
    .ldB   (ldB),
    .Psel  (Psel),
    .ldP   (ldP),
    .dataA (dataA),
    .dataB (dataB),
    .b0    (b0),
    .z     (z),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic la, input logic ca, input logic lb, input logic cb,
                       input logic lp, input logic ps, input logic [W-1:0] da,
                       input logic [W-1:0] db);
    ldA = la; ctrlA = ca; ldB = lb; ctrlB = cb; ldP = lp; Psel = ps;
    dataA = da; dataB = db;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected A values while shifting 0x0F left five times: upper bits fall off.
  logic [7:0] ovf_exp [5] = '{8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0};
  // Expected B/b0/z while shifting 4'b1010 right.
  logic [3:0] bsh_exp [4] = '{4'h5, 4'h2, 4'h1, 4'h0};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, '0, '0);
    #2;
    chk("rst_P", 16'(P), 16'h00);
    chk("rst_z", 16'(z), 16'h1);
    chk("rst_b0", 16'(b0), 16'h0);

    @(negedge clk);
    rst = 1'b1;

    // Load A=2, B=3, clear P
    drive(1, CTRL_LOAD, 1, CTRL_LOAD, 1, PSEL_CLR, 4'd2, 4'd3);
    tick();
    chk("ld_A", 16'(dut.a), 16'h02);
    chk("ld_B", 16'(dut.b), 16'h3);
    chk("ld_P", 16'(P), 16'h00);
    chk("ld_b0", 16'(b0), 16'h1);
    chk("ld_z", 16'(z), 16'h0);

    // 2 x 3
    drive(1, CTRL_SHIFT, 1, CTRL_SHIFT, 1, PSEL_ADD, 4'd0, 4'd0);
    tick();
    chk("m1_P", 16'(P), 16'h02);
    chk("m1_A", 16'(dut.a), 16'h04);
    chk("m1_B", 16'(dut.b), 16'h1);
    chk("m1_b0", 16'(b0), 16'h1);
    tick();
    chk("m2_P", 16'(P), 16'h06);
    chk("m2_A", 16'(dut.a), 16'h08);
    chk("m2_B", 16'(dut.b), 16'h0);
    chk("m2_z", 16'(z), 16'h1);
    chk("m2_b0", 16'(b0), 16'h0);

    // Hold with other inputs toggling
    for (int i = 0; i < 3; i++) begin
      drive(0, i[0], 0, ~i[0], 0, ~i[0], 4'(4'hF - i), 4'(4'h9 + i));
      tick();
      chk("hold_P", 16'(P), 16'h06);
      chk("hold_A", 16'(dut.a), 16'h08);
      chk("hold_B", 16'(dut.b), 16'h0);
      chk("hold_z", 16'(z), 16'h1);
      chk("hold_b0", 16'(b0), 16'h0);
    end

    // Async reset mid-cycle with A and P nonzero
    drive(0, 0, 0, 0, 0, 0, '0, '0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_P", 16'(P), 16'h00);
    chk("arst_A", 16'(dut.a), 16'h00);
    chk("arst_z", 16'(z), 16'h1);
    chk("arst_b0", 16'(b0), 16'h0);
    @(negedge clk);
    rst = 1'b1;

    // Shift overflow: A=0x0F then five left shifts
    drive(1, CTRL_LOAD, 0, 0, 0, 0, 4'hF, 4'h0);
    tick();
    chk("ovf_ld", 16'(dut.a), 16'h0F);
    drive(1, CTRL_SHIFT, 0, 0, 0, 0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ovf_A", 16'(dut.a), 16'(ovf_exp[i]));
    end

    // P wrap: A=0x80, clear P, add twice
    drive(1, CTRL_LOAD, 0, 0, 0, 0, 4'h8, 4'h0);
    tick();
    drive(1, CTRL_SHIFT, 0, 0, 0, 0, 4'h0, 4'h0);
    repeat (4) tick();
    chk("wrap_A", 16'(dut.a), 16'h80);
    drive(0, 0, 0, 0, 1, PSEL_CLR, 4'h0, 4'h0);
    tick();
    chk("wrap_clr", 16'(P), 16'h00);
    drive(0, 0, 0, 0, 1, PSEL_ADD, 4'h0, 4'h0);
    tick();
    chk("wrap_add1", 16'(P), 16'h80);
    tick();
    chk("wrap_add2", 16'(P), 16'h00);

    // B right shift and status bits
    drive(0, 0, 1, CTRL_LOAD, 0, 0, 4'h0, 4'hA);
    tick();
    chk("bsh_ld", 16'(dut.b), 16'hA);
    chk("bsh_ld_b0", 16'(b0), 16'h0);
    chk("bsh_ld_z", 16'(z), 16'h0);
    drive(0, 0, 1, CTRL_SHIFT, 0, 0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bsh_B", 16'(dut.b), 16'(bsh_exp[i]));
      chk("bsh_b0", 16'(b0), 16'(bsh_exp[i][0]));
      chk("bsh_z", 16'(z), 16'(bsh_exp[i] == 4'h0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
